l2_axi_bridge: RTL

L2_AXI_BRIDGE -- requirements
Module: l2_axi_bridge

---
 rtl/l2_axi_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/l2_axi_bridge.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/l2_axi_pkg.sv
// Shared types and constants for the L2-to-AXI block bridge.
// Holds the FSM state encoding, AXI tie-off codes and burst sizing helpers.
package l2_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_RDATA,
        ST_AW,
        ST_WDATA,
        ST_BRESP,
        ST_RESP
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic int beats_f(input int block_dw, input int axi_dw);
        return block_dw / axi_dw;
    endfunction

    // AxSIZE encoding for a full-width beat: log2(bytes per beat)
    function automatic logic [2:0] axi_size_f(input int axi_dw);
        return 3'($clog2(axi_dw / 8));
    endfunction

    localparam logic [2:0] AXI_SIZE = axi_size_f(32);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts at ptr.
// Ports: clk, rst, req (per-port), en (commit grant), gnt (one-hot).
module rr_arbiter #(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 en,
    output logic [NUM_PORTS-1:0] gnt
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] nxt;

    // Walk from the farthest candidate back to ptr so the
    // closest requester (in rotation order) is the last writer.
    always_comb begin
        int t;
        t   = 0;
        gnt = '0;
        nxt = ptr;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            t = int'(ptr) + k;
            if (t >= NUM_PORTS) t = t - NUM_PORTS;
            if (req[t[PW-1:0]]) begin
                gnt             = '0;
                gnt[t[PW-1:0]]  = 1'b1;
                nxt = (t == NUM_PORTS - 1) ? '0 : PW'(t + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en && |req) begin
            ptr <= nxt;
        end
    end

endmodule

// File: rtl/l2_axi_bridge.sv
// Bridges cache block refills/writebacks onto single AXI INCR bursts.
// Ports: req_* cache side (per port), resp_* completion, aw/w/b/ar/r AXI master.
module l2_axi_bridge
    import l2_axi_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int BLOCK_DW  = 256,
    parameter int AXI_DW    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS-1:0]          req_write,
    input  logic [NUM_PORTS*32-1:0]       req_addr,
    input  logic [NUM_PORTS*BLOCK_DW-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]          resp_valid,
    output logic [BLOCK_DW-1:0]           resp_data,
    output logic                          resp_err,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [31:0]                   awaddr,
    output logic [7:0]                    awlen,
    output logic [2:0]                    awsize,
    output logic [1:0]                    awburst,
    output logic                          wvalid,
    input  logic                          wready,
    output logic [AXI_DW-1:0]             wdata,
    output logic                          wlast,
    input  logic                          bvalid,
    output logic                          bready,
    input  logic [1:0]                    bresp,
    output logic                          arvalid,
    input  logic                          arready,
    output logic [31:0]                   araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    input  logic                          rvalid,
    output logic                          rready,
    input  logic [AXI_DW-1:0]             rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast
);

    localparam int BEATS = beats_f(BLOCK_DW, AXI_DW);
    localparam int CW    = (BEATS > 8) ? $clog2(BEATS) : 3;
    localparam int OFS   = $clog2(BLOCK_DW / 8);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_inc;
    logic [NUM_PORTS-1:0]   gnt_q;
    logic [NUM_PORTS-1:0]   arb_gnt;
    logic [BLOCK_DW-1:0]    wbuf;
    logic [31:0]            sel_addr;
    logic [31:0]            blk_addr;
    logic [BLOCK_DW-1:0]    sel_wdata;
    logic                   sel_write;

    assign awlen   = 8'(BEATS - 1);
    assign arlen   = 8'(BEATS - 1);
    assign awsize  = axi_size_f(AXI_DW);
    assign arsize  = axi_size_f(AXI_DW);
    assign awburst = AXI_BURST_INCR;
    assign arburst = AXI_BURST_INCR;
    assign cnt_inc = cnt + CW'(1);

    rr_arbiter #(
        .NUM_PORTS(NUM_PORTS)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .en  (state == ST_IDLE),
        .gnt (arb_gnt)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (arb_gnt[i]) begin
                sel_addr  = req_addr[i*32 +: 32];
                sel_wdata = req_wdata[i*BLOCK_DW +: BLOCK_DW];
                sel_write = req_write[i];
            end
        end
        blk_addr          = sel_addr;
        blk_addr[OFS-1:0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            gnt_q      <= '0;
            wbuf       <= '0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            awvalid    <= 1'b0;
            awaddr     <= '0;
            wvalid     <= 1'b0;
            wdata      <= '0;
            wlast      <= 1'b0;
            bready     <= 1'b0;
            arvalid    <= 1'b0;
            araddr     <= '0;
            rready     <= 1'b0;
        end else begin
            req_ready  <= '0;
            resp_valid <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (|arb_gnt) begin
                        req_ready <= arb_gnt;
                        gnt_q     <= arb_gnt;
                        resp_err  <= 1'b0;
                        cnt       <= '0;
                        wbuf      <= sel_wdata;
                        if (sel_write) begin
                            awaddr  <= blk_addr;
                            awvalid <= 1'b1;
                            state   <= ST_AW;
                        end else begin
                            araddr  <= blk_addr;
                            arvalid <= 1'b1;
                            state   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (rvalid && rready) begin
                        resp_data[int'(cnt)*AXI_DW +: AXI_DW] <= rdata;
                        // Burst length is fixed: rlast must line up
                        // exactly with the final counted beat.
                        if (cnt == LAST) begin
                            rready     <= 1'b0;
                            resp_valid <= gnt_q;
                            resp_err   <= resp_err
                                        | (rresp != AXI_RESP_OKAY)
                                        | !rlast;
                            state      <= ST_RESP;
                        end else begin
                            resp_err <= resp_err
                                      | (rresp != AXI_RESP_OKAY)
                                      | rlast;
                            cnt      <= cnt_inc;
                        end
                    end
                end
                ST_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wdata   <= wbuf[AXI_DW-1:0];
                        wlast   <= (LAST == '0);
                        state   <= ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (wready) begin
                        if (cnt == LAST) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            state  <= ST_BRESP;
                        end else begin
                            cnt   <= cnt_inc;
                            wdata <= wbuf[int'(cnt_inc)*AXI_DW +: AXI_DW];
                            wlast <= (cnt_inc == LAST);
                        end
                    end
                end
                ST_BRESP: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        resp_err   <= resp_err | (bresp != AXI_RESP_OKAY);
                        resp_valid <= gnt_q;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
